dmem_arbiter: RTL and testbench

- Sequences and shares the single-port data memory between two requesters: the pipeline memory stage (CPU port) and a debug/DMA master (DMA port).
- Performs one memory transaction at a time with fixed multi-cycle latency.
- Acknowledges each requester when its transaction completes.
- Generates the memory-stage stall that feeds the pipeline's combined stall.

---
 rtl/dmem_arbiter_if.sv | 33 +++
 rtl/dmem_arbiter.sv | 97 +++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and memory-side signals of the data memory arbiter
// slave: arbiter view (takes requests, drives acks/rdata, memory strobes and mem_stall)
// master: environment view (requesters and memory model)
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req, cpu_we, cpu_ack;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic                  dma_req, dma_we, dma_ack;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata, dma_rdata;
  logic                  mem_read, mem_write, mem_stall;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_stall,
    input  mem_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_stall,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU memory stage and a DMA master
// Ports: clk; reset (async, active high); bus (slave) with CPU/DMA request ports,
// registered memory strobes/address/data, and combinational mem_stall.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DMA_MAX_WAIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int WW = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(DMA_MAX_WAIT);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;
  state_t state, state_d;
  logic owner, owner_d;
  logic rd, rd_d, wr, wr_d, cpu_ack, cpu_ack_d, dma_ack, dma_ack_d, dma_win;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [DATA_WIDTH-1:0] wdata, wdata_d, cpu_rdata, cpu_rdata_d, dma_rdata, dma_rdata_d;
  logic [WW-1:0] wait_cnt, wait_d, wait_inc;
  // owner: 1 = DMA. A starved DMA takes priority once it has lost DMA_MAX_WAIT cycles.
  assign dma_win  = bus.dma_req & (~bus.cpu_req | (wait_cnt == WMAX));
  assign wait_inc = (wait_cnt == WMAX) ? wait_cnt : wait_cnt + WW'(1);
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    addr_d      = addr;
    wdata_d     = wdata;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    case (state)
      IDLE: if (bus.cpu_req | bus.dma_req) begin
        state_d = ISSUE;
        owner_d = dma_win;
        wr_d    = dma_win ? bus.dma_we : bus.cpu_we;
        rd_d    = ~wr_d;
        addr_d  = dma_win ? bus.dma_addr : bus.cpu_addr;
        wdata_d = dma_win ? bus.dma_wdata : bus.cpu_wdata;
      end
      ISSUE: begin
        state_d   = wr ? DONE : RESP;
        cpu_ack_d = wr & ~owner;
        dma_ack_d = wr & owner;
      end
      RESP: begin
        state_d     = DONE;
        cpu_rdata_d = owner ? cpu_rdata : bus.mem_rdata;
        dma_rdata_d = owner ? bus.mem_rdata : dma_rdata;
        cpu_ack_d   = ~owner;
        dma_ack_d   = owner;
      end
      DONE: state_d = IDLE;
    endcase
    // With dma_req high in IDLE a grant always happens: either the DMA wins or the CPU does.
    wait_d = !bus.dma_req ? '0 : (state == IDLE) ? (dma_win ? '0 : wait_inc) : owner ? wait_cnt : wait_inc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rd        <= rd_d;
      wr        <= wr_d;
      addr      <= addr_d;
      wdata     <= wdata_d;
      cpu_rdata <= cpu_rdata_d;
      dma_rdata <= dma_rdata_d;
      cpu_ack   <= cpu_ack_d;
      dma_ack   <= dma_ack_d;
      wait_cnt  <= wait_d;
    end
  assign bus.mem_read  = rd;
  assign bus.mem_write = wr;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.dma_rdata = dma_rdata;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.dma_ack   = dma_ack;
  assign bus.mem_stall = bus.cpu_req & ~cpu_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with an ack scoreboard and memory model
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  typedef struct {logic we; logic [31:0] data;} exp_t;
  exp_t cpu_q[$];
  exp_t dma_q[$];
  logic [31:0] mem [0:255];
  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DMA_MAX_WAIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  // Scoreboard: every ack must match a queued expectation; loads also compare data.
  always @(negedge clk) begin
    exp_t e;
    #2;
    chk1("ack_exclusive", bus.cpu_ack & bus.dma_ack, 1'b0);
    chk1("strobe_exclusive", bus.mem_read & bus.mem_write, 1'b0);
    if (bus.cpu_ack) begin
      chk1("cpu_ack_expected", cpu_q.size() != 0, 1'b1);
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        if (!e.we) chk("cpu_rdata_sb", bus.cpu_rdata, e.data);
      end
    end
    if (bus.dma_ack) begin
      chk1("dma_ack_expected", dma_q.size() != 0, 1'b1);
      if (dma_q.size() != 0) begin
        e = dma_q.pop_front();
        if (!e.we) chk("dma_rdata_sb", bus.dma_rdata, e.data);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h08] = 32'h12345678;
    mem[8'h0c] = 32'hCAFEF00D;
    bus.mem_rdata = 32'h0;
    reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
    repeat (2) cyc;
    #1;
    chk1("rst_read", bus.mem_read, 1'b0);
    chk1("rst_write", bus.mem_write, 1'b0);
    chk1("rst_cpu_ack", bus.cpu_ack, 1'b0);
    chk1("rst_dma_ack", bus.dma_ack, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_dma_rdata", bus.dma_rdata, 32'h0);
    chk("rst_state", 32'(dut.state), 32'd0);
    cyc; reset = 1'b0;
    // CPU store
    cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10; bus.cpu_wdata = 32'hDEADBEEF;
    cpu_q.push_back('{we: 1'b1, data: 32'h0});
    #1; chk1("st_stall_c0", bus.mem_stall, 1'b1);
    cyc; #1;
    chk1("st_write_c1", bus.mem_write, 1'b1);
    chk1("st_read_c1", bus.mem_read, 1'b0);
    chk("st_addr_c1", bus.mem_addr, 32'h10);
    chk("st_wdata_c1", bus.mem_wdata, 32'hDEADBEEF);
    chk1("st_stall_c1", bus.mem_stall, 1'b1);
    cyc; #1;
    chk1("st_ack_c2", bus.cpu_ack, 1'b1);
    chk1("st_stall_c2", bus.mem_stall, 1'b0);
    chk1("st_write_c2", bus.mem_write, 1'b0);
    cyc; bus.cpu_req = 1'b0; #1;
    chk1("st_ack_c3", bus.cpu_ack, 1'b0);
    // CPU load of the stored word
    cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    cpu_q.push_back('{we: 1'b0, data: 32'hDEADBEEF});
    cyc; #1;
    chk1("ld_read_c1", bus.mem_read, 1'b1);
    cyc; #1;
    chk1("ld_ack_c2", bus.cpu_ack, 1'b0);
    chk1("ld_read_c2", bus.mem_read, 1'b0);
    cyc; #1;
    chk1("ld_ack_c3", bus.cpu_ack, 1'b1);
    chk("ld_rdata_c3", bus.cpu_rdata, 32'hDEADBEEF);
    cyc; bus.cpu_req = 1'b0; #1;
    chk("ld_rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);
    chk1("ld_ack_c4", bus.cpu_ack, 1'b0);
    // Simultaneous loads: CPU first, then DMA
    cyc;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h20;
    cpu_q.push_back('{we: 1'b0, data: 32'hDEADBEEF});
    dma_q.push_back('{we: 1'b0, data: 32'h12345678});
    cyc; #1;
    chk("both_addr_c1", bus.mem_addr, 32'h10);
    repeat (2) cyc; #1;
    chk1("both_cpu_ack_c3", bus.cpu_ack, 1'b1);
    chk1("both_dma_ack_c3", bus.dma_ack, 1'b0);
    cyc; bus.cpu_req = 1'b0; #1;
    chk("both_wait_c4", 32'(dut.wait_cnt), 32'd4);
    cyc; #1;
    chk1("both_read_c5", bus.mem_read, 1'b1);
    chk("both_addr_c5", bus.mem_addr, 32'h20);
    chk("both_wait_c5", 32'(dut.wait_cnt), 32'd0);
    repeat (2) cyc; #1;
    chk1("both_dma_ack_c7", bus.dma_ack, 1'b1);
    chk("both_dma_rdata_c7", bus.dma_rdata, 32'h12345678);
    cyc; bus.dma_req = 1'b0;
    // Back-to-back CPU loads while a DMA load starves
    cyc;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h20;
    cpu_q.push_back('{we: 1'b0, data: 32'hDEADBEEF});
    dma_q.push_back('{we: 1'b0, data: 32'h12345678});
    cpu_q.push_back('{we: 1'b0, data: 32'hCAFEF00D});
    repeat (3) cyc; #1;
    chk1("b2b_cpu_ack_c3", bus.cpu_ack, 1'b1);
    cyc; bus.cpu_addr = 32'h30; #1;
    chk("b2b_wait_c4", 32'(dut.wait_cnt), 32'd4);
    cyc; #1;
    chk("b2b_addr_c5", bus.mem_addr, 32'h20);
    chk("b2b_wait_c5", 32'(dut.wait_cnt), 32'd0);
    chk1("b2b_stall_c5", bus.mem_stall, 1'b1);
    cyc; #1;
    chk1("b2b_stall_c6", bus.mem_stall, 1'b1);
    cyc; #1;
    chk1("b2b_dma_ack_c7", bus.dma_ack, 1'b1);
    chk1("b2b_stall_c7", bus.mem_stall, 1'b1);
    cyc; bus.dma_req = 1'b0; #1;
    chk1("b2b_stall_c8", bus.mem_stall, 1'b1);
    cyc; #1;
    chk("b2b_addr_c9", bus.mem_addr, 32'h30);
    chk1("b2b_read_c9", bus.mem_read, 1'b1);
    repeat (2) cyc; #1;
    chk1("b2b_cpu_ack_c11", bus.cpu_ack, 1'b1);
    cyc; bus.cpu_req = 1'b0;
    // Reset during the ISSUE cycle of a DMA write
    cyc;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h40; bus.dma_wdata = 32'h55AA55AA;
    cyc; #1;
    chk1("rw_write_c1", bus.mem_write, 1'b1);
    #1; reset = 1'b1; bus.dma_req = 1'b0; #1;
    chk1("rw_write_abort", bus.mem_write, 1'b0);
    chk("rw_state_abort", 32'(dut.state), 32'd0);
    chk1("rw_dma_ack_abort", bus.dma_ack, 1'b0);
    cyc; #1;
    chk1("rw_dma_ack_c2", bus.dma_ack, 1'b0);
    cyc; reset = 1'b0;
    cyc;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h10;
    cpu_q.push_back('{we: 1'b0, data: 32'hDEADBEEF});
    #1; chk("rw_cpu_rdata_cleared", bus.cpu_rdata, 32'h0);
    repeat (3) cyc; #1;
    chk1("rw_cpu_ack_c3", bus.cpu_ack, 1'b1);
    chk("rw_cpu_rdata_c3", bus.cpu_rdata, 32'hDEADBEEF);
    cyc; bus.cpu_req = 1'b0;
    // DMA drops dma_req during RESP of its read
    cyc;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h30;
    dma_q.push_back('{we: 1'b0, data: 32'hCAFEF00D});
    cyc; #1;
    chk1("drop_read_c1", bus.mem_read, 1'b1);
    cyc; bus.dma_req = 1'b0;
    cyc; #1;
    chk1("drop_dma_ack_c3", bus.dma_ack, 1'b1);
    chk("drop_dma_rdata_c3", bus.dma_rdata, 32'hCAFEF00D);
    for (int i = 4; i < 7; i++) begin
      cyc; #1;
      chk("drop_state_idle", 32'(dut.state), 32'd0);
      chk1("drop_no_read", bus.mem_read, 1'b0);
      chk1("drop_no_ack", bus.dma_ack, 1'b0);
    end
    cyc; #3;
    chk("sb_cpu_drained", 32'(cpu_q.size()), 32'd0);
    chk("sb_dma_drained", 32'(dma_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
